// File: rtl/clint_arbiter.sv
// Round-robin arbiter sharing the CLINT MMIO register port between the core LSU (port 0)
// and the debug/external bus (port 1). Each transaction runs IDLE -> ACCESS -> RESP.
module clint_arbiter #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [1:0]           i_req,
    input  logic [1:0]           i_we,
    input  logic [1:0]           i_addr0,
    input  logic [1:0]           i_addr1,
    input  logic [REG_WIDTH-1:0] i_wdata0,
    input  logic [REG_WIDTH-1:0] i_wdata1,
    output logic [1:0]           o_ack,
    output logic                 o_err,
    output logic [REG_WIDTH-1:0] o_rdata,
    output logic                 o_clint_we,
    output logic [1:0]           o_clint_addr,
    output logic [REG_WIDTH-1:0] o_clint_wdata,
    input  logic [REG_WIDTH-1:0] i_clint_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_RSVD = 2'd3;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_ptr;
    logic                 r_id;
    logic                 r_we;
    logic [1:0]           r_addr;
    logic [REG_WIDTH-1:0] r_wdata;
    logic [REG_WIDTH-1:0] r_rdata;
    logic                 w_grant;
    logic                 w_winner;

    // Single requester wins outright; a tie goes to the pointer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_winner = r_ptr;
        case (i_req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            default: w_winner = r_ptr;
        endcase
        w_grant = (r_state == S_IDLE) && (i_req != 2'b00);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_req != 2'b00) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The command is latched once per grant; requester inputs are ignored until IDLE.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 2'd0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_ptr   <= ~w_winner;
            r_id    <= w_winner;
            r_we    <= i_we[w_winner];
            r_addr  <= w_winner ? i_addr1 : i_addr0;
            r_wdata <= w_winner ? i_wdata1 : i_wdata0;
        end
    end

    // Capture at the end of ACCESS; a write therefore returns the pre-write value.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_rdata <= '0;
        end else if (r_state == S_ACCESS) begin
            r_rdata <= (r_addr == ADDR_RSVD) ? '0 : i_clint_rdata;
        end
    end

    // Strobes decode from state and latches only, so reset kills them asynchronously.
    always_comb begin
        o_ack      = 2'b00;
        o_err      = 1'b0;
        o_clint_we = 1'b0;
        if (r_state == S_ACCESS) begin
            o_clint_we = r_we && (r_addr != ADDR_RSVD);
        end
        if (r_state == S_RESP) begin
            o_ack[r_id] = 1'b1;
            o_err       = (r_addr == ADDR_RSVD);
        end
    end

    assign o_clint_addr  = r_addr;
    assign o_clint_wdata = r_wdata;
    assign o_rdata       = r_rdata;

endmodule

// File: doc/clint_arbiter.md
Name: clint_arbiter

Overview:
Two-port arbiter and sequencer that shares the single CLINT MMIO register port (MSIP/MTIME/MTIMECMP) between two requesters: port 0 is the core load/store unit and port 1 is the debug/external bus. It grants one request at a time using round-robin priority. It drives the CLINT write-enable, address and data lines, captures read data, and returns an ack (plus an error flag) to the granted requester.

Parameters:
REG_WIDTH, 32, data width of the CLINT registers and requester data buses.

Ports:
clk  input  1  system clock; all state updates on rising edge.
arstn  input  1  asynchronous active-low reset.
i_req  input  2  per-requester request; bit n = requester n.
i_we  input  2  per-requester write flag; sampled with i_req.
i_addr0  input  2  requester 0 register index (0 MSIP, 1 MTIME, 2 MTIMECMP, 3 reserved).
i_addr1  input  2  requester 1 register index.
i_wdata0  input  REG_WIDTH  requester 0 write data.
i_wdata1  input  REG_WIDTH  requester 1 write data.
o_ack  output  2  one-cycle completion pulse per requester.
o_err  output  1  valid with o_ack; set when the completed access targeted index 3.
o_rdata  output  REG_WIDTH  read data; valid with o_ack; shared by both requesters.
o_clint_we  output  1  CLINT write enable.
o_clint_addr  output  2  CLINT register index.
o_clint_wdata  output  REG_WIDTH  CLINT write data.
i_clint_rdata  input  REG_WIDTH  CLINT combinational read data for o_clint_addr.

Behaviour:
- Reset (arstn low, asynchronous):
  - state = IDLE; priority pointer = requester 0.
  - o_ack = 0, o_err = 0, o_rdata = 0.
  - o_clint_we = 0, o_clint_addr = 0, o_clint_wdata = 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any i_req bit is set, choose a winner and move to ACCESS. Otherwise stay in IDLE.
  - ACCESS: always lasts exactly one cycle, then moves to RESP.
  - RESP: always lasts exactly one cycle, then moves to IDLE.
- Arbitration (IDLE only):
  - If exactly one request is present, that requester wins.
  - If both are present, the requester named by the priority pointer wins.
  - On each grant, the pointer moves to the other requester (the loser of a tie, or simply the non-winner).
- Command latch: on the IDLE->ACCESS edge, latch the winner id, we, addr and wdata. Requester inputs are ignored from then until the next IDLE.
- ACCESS:
  - o_clint_addr and o_clint_wdata show the latched values.
  - o_clint_we = latched_we AND (latched_addr != 3). It is decoded from state and latches, never from live inputs.
  - At the end of the cycle, i_clint_rdata is captured into o_rdata on both reads and writes. A write captures the pre-write value.
  - For reads of index 3, o_rdata = 0 regardless of i_clint_rdata.
- RESP:
  - o_ack[winner] = 1 for this cycle only; o_err = (latched_addr == 3).
  - o_clint_we = 0.
  - o_rdata holds until the next capture.
- Latency: a request sampled at edge k gets o_clint_we during cycle k..k+1 and o_ack during cycle k+1..k+2. Total 3 cycles per transaction, so one transaction per 3 cycles back-to-back.
- Requester protocol:
  - Hold i_req and the command stable until o_ack.
  - A request dropped while in IDLE before being sampled is not serviced.
  - A request dropped after latching is still completed and acked.
  - i_req still high in the cycle after o_ack is treated as a new request.
- MTIME increments every cycle in the CLINT, so the captured value is MTIME as seen during ACCESS.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is issued, and o_clint_we drops immediately (asynchronously).
- o_ack is never asserted for both bits together. At most one CLINT write occurs per transaction.

Test Plan:
- Read of MTIMECMP, requester 0 only: CLINT preloaded with MTIMECMP = 0x0000_0100; i_req = 01, i_we = 0, i_addr0 = 2 at edge 0 -> o_ack = 01 in cycle 2, o_rdata = 0x100, o_err = 0, o_clint_we never asserted.
- Write of MSIP, requester 1: i_req = 10, i_we = 10, i_addr1 = 0, i_wdata1 = 1 -> exactly one o_clint_we cycle with addr = 0, data = 1; o_ack = 10 two cycles after sampling; CLINT software interrupt asserts the following cycle.
- Simultaneous requests held high, both writing different values to MTIMECMP -> grants alternate 0,1,0,1 starting with requester 0 after reset; each ack comes 3 cycles after the previous one; final MTIMECMP equals the last granted requester's value.
- Reserved index: requester 0 writes 0xDEAD_BEEF to index 3 -> o_clint_we stays 0, o_ack = 01 with o_err = 1, o_rdata = 0.
- Reset mid-operation: assert arstn low during ACCESS of a write -> o_clint_we falls immediately, no o_ack, outputs zero, pointer = 0; after release a pending requester 1 request is served normally.
- Request withdrawn: requester 1 pulses i_req for 1 cycle while requester 0 is in ACCESS -> requester 1 is never acked; requester 0 completes normally.
